id_ex_stage: RTL and testbench

ID/EX pipeline register for the five-stage CPU, with built-in load-use hazard detection, bubble insertion, branch flush and cache-stall freeze. It latches decoded operands and control from ID and presents the EX-stage register indices (EXRs1, EXRs2, EXRd) consumed by the forwarding unit and the ALU operand muxes. It also keeps two performance counters (bubbles inserted, cache-stall cycles).

---
 rtl/id_ex_stage_pkg.sv | 17 +
 rtl/id_ex_hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: control-word bit positions and field widths.
package id_ex_stage_pkg;

  localparam int CTRL_W  = 8;
  localparam int FUNCT_W = 10;
  localparam int REG_W   = 5;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_BRANCH   = 0;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detection and PC / IF-ID write enables; purely combinational.
module id_ex_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             mem_stall_i,
  output logic             hazard_o,
  output logic             pc_write_o,
  output logic             ifid_write_o
);

  // Rs2 is compared even for I-type instructions; a rare false stall is cheaper than decoding the format here.
  assign hazard_o     = ex_memread_i && (ex_rd_i != '0) &&
                        ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign pc_write_o   = !hazard_o && !mem_stall_i;
  assign ifid_write_o = !hazard_o && !mem_stall_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle latency; freezes on mem_stall_i, inserts a bubble on load-use hazard or flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mem_stall_i,
  input  logic               flush_i,
  input  logic [4:0]         IDRs1_i,
  input  logic [4:0]         IDRs2_i,
  input  logic [4:0]         IDRd_i,
  input  logic [DATA_W-1:0]  IDRS1data_i,
  input  logic [DATA_W-1:0]  IDRS2data_i,
  input  logic [DATA_W-1:0]  IDImm_i,
  input  logic [9:0]         IDFunct_i,
  input  logic [7:0]         IDCtrl_i,
  output logic [4:0]         EXRs1_o,
  output logic [4:0]         EXRs2_o,
  output logic [4:0]         EXRd_o,
  output logic [DATA_W-1:0]  EXRS1data_o,
  output logic [DATA_W-1:0]  EXRS2data_o,
  output logic [DATA_W-1:0]  EXImm_o,
  output logic [9:0]         EXFunct_o,
  output logic [7:0]         EXCtrl_o,
  output logic               hazard_o,
  output logic               PCWrite_o,
  output logic               IFIDWrite_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  logic [REG_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0]  d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d, stall_cnt_q, stall_cnt_d;
  logic               hazard;
  logic               insert_bubble;

  id_ex_hazard_detect u_hazard (
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i      (rd_q),
    .id_rs1_i     (IDRs1_i),
    .id_rs2_i     (IDRs2_i),
    .mem_stall_i  (mem_stall_i),
    .hazard_o     (hazard),
    .pc_write_o   (PCWrite_o),
    .ifid_write_o (IFIDWrite_o)
  );

  // A stall masks hazard/flush; they are re-evaluated once the cache releases the pipeline.
  assign insert_bubble = !mem_stall_i && (hazard || flush_i);

  always_comb begin
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    ctrl_d  = ctrl_q;
    if (insert_bubble) begin
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      imm_d   = '0;
      funct_d = '0;
      ctrl_d  = '0;
    end else if (!mem_stall_i) begin
      rs1_d   = IDRs1_i;
      rs2_d   = IDRs2_i;
      rd_d    = IDRd_i;
      d1_d    = IDRS1data_i;
      d2_d    = IDRS2data_i;
      imm_d   = IDImm_i;
      funct_d = IDFunct_i;
      ctrl_d  = IDCtrl_i;
    end
    bubble_cnt_d = bubble_cnt_q + CNT_W'(insert_bubble);
    stall_cnt_d  = stall_cnt_q + CNT_W'(mem_stall_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign EXRs1_o      = rs1_q;
  assign EXRs2_o      = rs2_q;
  assign EXRd_o       = rd_q;
  assign EXRS1data_o  = d1_q;
  assign EXRS2data_o  = d2_q;
  assign EXImm_o      = imm_q;
  assign EXFunct_o    = funct_q;
  assign EXCtrl_o     = ctrl_q;
  assign hazard_o     = hazard;
  assign bubble_cnt_o = bubble_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction stream, expected results queued by the driver and checked by a monitor.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int K_LOAD = 0;
  localparam int K_BUB  = 1;
  localparam int K_HOLD = 2;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
    logic [9:0]  funct;
    logic [31:0] d1, d2, imm;
  } ex_t;

  typedef struct packed {
    ex_t        ex;
    logic       haz;
    logic       pcw;
    logic [3:0] b;
    logic [3:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_stall = 1'b0, flush = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] id_d1 = '0, id_d2 = '0, id_imm = '0;
  logic [9:0]  id_funct = '0;
  logic [7:0]  id_ctrl = '0;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [9:0]  ex_funct;
  logic [7:0]  ex_ctrl;
  logic        hazard, pcw, ifidw;
  logic [CNT_W-1:0] bcnt, scnt;

  int   total = 0;
  int   bad = 0;
  int   seq = 0;
  exp_t q[$];
  ex_t  last_ex = '0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .mem_stall_i(mem_stall), .flush_i(flush),
    .IDRs1_i(id_rs1), .IDRs2_i(id_rs2), .IDRd_i(id_rd),
    .IDRS1data_i(id_d1), .IDRS2data_i(id_d2), .IDImm_i(id_imm),
    .IDFunct_i(id_funct), .IDCtrl_i(id_ctrl),
    .EXRs1_o(ex_rs1), .EXRs2_o(ex_rs2), .EXRd_o(ex_rd),
    .EXRS1data_o(ex_d1), .EXRS2data_o(ex_d2), .EXImm_o(ex_imm),
    .EXFunct_o(ex_funct), .EXCtrl_o(ex_ctrl),
    .hazard_o(hazard), .PCWrite_o(pcw), .IFIDWrite_o(ifidw),
    .bubble_cnt_o(bcnt), .stall_cnt_o(scnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One ID instruction per call; consumes exactly one rising edge.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [7:0] ctrl, input logic stall, input logic fl,
                      input logic e_haz, input int kind, input int e_b, input int e_s);
    exp_t e;
    @(posedge clk);
    #2;
    seq++;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    id_funct = 10'(seq * 7);
    id_d1 = 32'hA000_0000 | seq;
    id_d2 = 32'hB000_0000 | seq;
    id_imm = 32'hFFFF_F000 | seq;
    mem_stall = stall; flush = fl;
    e = '0;
    e.haz = e_haz;
    e.pcw = !e_haz && !stall;
    case (kind)
      K_LOAD: e.ex = '{rs1: rs1, rs2: rs2, rd: rd, ctrl: ctrl, funct: id_funct,
                       d1: id_d1, d2: id_d2, imm: id_imm};
      K_BUB:  e.ex = '0;
      default: e.ex = last_ex;
    endcase
    last_ex = e.ex;
    e.b = 4'(e_b);
    e.s = 4'(e_s);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
        check("hazard_o", 32'(hazard), 32'(e.haz));
        check("PCWrite_o", 32'(pcw), 32'(e.pcw));
        check("IFIDWrite_o", 32'(ifidw), 32'(e.pcw));
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("EXRs1", 32'(ex_rs1), 32'(e.ex.rs1));
        check("EXRs2", 32'(ex_rs2), 32'(e.ex.rs2));
        check("EXRd", 32'(ex_rd), 32'(e.ex.rd));
        check("EXCtrl", 32'(ex_ctrl), 32'(e.ex.ctrl));
        check("EXFunct", 32'(ex_funct), 32'(e.ex.funct));
        check("EXRS1data", ex_d1, e.ex.d1);
        check("EXRS2data", ex_d2, e.ex.d2);
        check("EXImm", ex_imm, e.ex.imm);
        check("bubble_cnt", 32'(bcnt), 32'(e.b));
        check("stall_cnt", 32'(scnt), 32'(e.s));
      end
    end
  end

  initial begin : driver
    #12;
    check("rst EXRd", 32'(ex_rd), 32'd0);
    check("rst EXCtrl", 32'(ex_ctrl), 32'd0);
    check("rst hazard", 32'(hazard), 32'd0);
    check("rst PCWrite", 32'(pcw), 32'd1);
    check("rst bubble_cnt", 32'(bcnt), 32'd0);
    rst = 1'b0;

    // lw x5 then dependent add x7,x5,x3: one bubble, then add enters EX
    step(5'd2, 5'd0, 5'd5, 8'hE2, 0, 0, 0, K_LOAD, 0, 0);
    step(5'd5, 5'd3, 5'd7, 8'h88, 0, 0, 1, K_BUB,  1, 0);
    step(5'd5, 5'd3, 5'd7, 8'h88, 0, 0, 0, K_LOAD, 1, 0);
    // load to x0 followed by a reader of x0: no hazard
    step(5'd1, 5'd4, 5'd0, 8'hE2, 0, 0, 0, K_LOAD, 1, 0);
    step(5'd9, 5'd0, 5'd6, 8'h88, 0, 0, 0, K_LOAD, 1, 0);
    // flush of an instruction with ctrl A4
    step(5'd1, 5'd2, 5'd3, 8'hA4, 0, 1, 0, K_BUB,  2, 0);
    // hazard (via rs2) and flush together count once
    step(5'd1, 5'd0, 5'd8, 8'hE2, 0, 0, 0, K_LOAD, 2, 0);
    step(5'd4, 5'd8, 5'd9, 8'h88, 0, 1, 1, K_BUB,  3, 0);
    // cache stall for 3 cycles over a load-use pair
    step(5'd0, 5'd0, 5'd10, 8'hE2, 0, 0, 0, K_LOAD, 3, 0);
    step(5'd10, 5'd1, 5'd11, 8'h88, 1, 0, 1, K_HOLD, 3, 1);
    step(5'd10, 5'd1, 5'd11, 8'h88, 1, 0, 1, K_HOLD, 3, 2);
    step(5'd10, 5'd1, 5'd11, 8'h88, 1, 0, 1, K_HOLD, 3, 3);
    step(5'd10, 5'd1, 5'd11, 8'h88, 0, 0, 1, K_BUB,  4, 3);
    step(5'd10, 5'd1, 5'd11, 8'h88, 0, 0, 0, K_LOAD, 4, 3);
    // 17 flushes through a 4-bit counter: 4+17 wraps to 5
    for (int k = 1; k <= 17; k++)
      step(5'd1, 5'd2, 5'd3, 8'hA4, 0, 1, 0, K_BUB, (4 + k) % 16, 3);
    // lw x12 then freeze, reset arrives mid-stall
    step(5'd0, 5'd0, 5'd12, 8'hE2, 0, 0, 0, K_LOAD, 5, 3);
    step(5'd0, 5'd0, 5'd0, 8'h88, 1, 0, 0, K_HOLD, 5, 4);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    #1 rst = 1'b1;
    #1;
    check("async rst EXRd", 32'(ex_rd), 32'd0);
    check("async rst EXCtrl", 32'(ex_ctrl), 32'd0);
    check("async rst bubble_cnt", 32'(bcnt), 32'd0);
    check("async rst stall_cnt", 32'(scnt), 32'd0);
    check("async rst hazard", 32'(hazard), 32'd0);
    check("async rst PCWrite", 32'(pcw), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
